// File: rtl/qeciphy_traffic_gen_chk.sv
// QECIPHY link traffic generator and checker.
// TX side emits an increment / PRBS-31 / walking-one AXI-stream pattern.
// RX side hunts for the same pattern, locks after a run of matching beats,
// then counts checked words and errors and captures the first bad beat.
module qeciphy_traffic_gen_chk #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8
) (
  input  logic                  ACLK,
  input  logic                  ARST,
  input  logic                  EN,
  input  logic [1:0]            MODE,
  input  logic                  INJ_ERR,
  input  logic                  CLR,
  output logic [DATA_WIDTH-1:0] TX_TDATA,
  output logic                  TX_TVALID,
  input  logic                  TX_TREADY,
  input  logic [DATA_WIDTH-1:0] RX_TDATA,
  input  logic                  RX_TVALID,
  output logic                  RX_TREADY,
  output logic                  LOCKED,
  output logic                  ERROR,
  output logic [CNT_WIDTH-1:0]  ERR_CNT,
  output logic [CNT_WIDTH-1:0]  WORD_CNT,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_RX,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_EXP
);

  // Run / bad-beat counters only need to reach LOCK_COUNT-1 / LOSS_COUNT-1.
  localparam int RUN_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int BAD_W = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;

  localparam logic [1:0] PAT_INC  = 2'd0;
  localparam logic [1:0] PAT_PRBS = 2'd1;
  localparam logic [1:0] PAT_WALK = 2'd2;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // First PRBS-31 word: s[0..30] all ones, remaining bits by the recurrence.
  function automatic logic [DATA_WIDTH-1:0] prbs_seed();
    logic [DATA_WIDTH-1:0] s;
    s       = '0;
    s[30:0] = '1;
    for (int k = 31; k < DATA_WIDTH; k++) s[k] = s[k-31] ^ s[k-28];
    return s;
  endfunction

  // Next PRBS-31 word. Only the last 31 bits of w are needed: they are the
  // newest stream history, and every new bit is derived from that window.
  function automatic logic [DATA_WIDTH-1:0] prbs_next(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH+30:0] s;
    s       = '0;
    s[30:0] = w[DATA_WIDTH-1 -: 31];
    for (int k = 31; k < DATA_WIDTH + 31; k++) s[k] = s[k-31] ^ s[k-28];
    return s[DATA_WIDTH+30:31];
  endfunction

  localparam logic [DATA_WIDTH-1:0] PRBS_SEED = prbs_seed();

  function automatic logic [DATA_WIDTH-1:0] seed_of(input logic [1:0] m);
    case (m)
      PAT_PRBS: return PRBS_SEED;
      PAT_WALK: return DATA_WIDTH'(1);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0]            m,
                                                      input logic [DATA_WIDTH-1:0] w);
    case (m)
      PAT_PRBS: return prbs_next(w);
      PAT_WALK: return {w[DATA_WIDTH-2:0], w[DATA_WIDTH-1]};
      default:  return w + DATA_WIDTH'(1);
    endcase
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Pattern 3 behaves exactly like pattern 0, so fold it away once here.
  logic [1:0] mode_n;
  assign mode_n    = (MODE == 2'd3) ? PAT_INC : MODE;
  assign RX_TREADY = 1'b1;

  // ---------------------------------------------------------------------
  // Generator
  // ---------------------------------------------------------------------
  logic [1:0]            gen_mode;   // pattern latched when TX_TVALID rises
  logic [DATA_WIDTH-1:0] tx_word;    // clean sequence value, never corrupted
  logic                  inj_pend;
  logic                  inj_now;
  logic [DATA_WIDTH-1:0] flip;
  logic [DATA_WIDTH-1:0] idle_seed;
  logic [DATA_WIDTH-1:0] gen_next;

  // Next-word and corruption mask for the generator.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inj_now   = inj_pend | INJ_ERR;
    flip      = '0;
    flip[0]   = inj_now;
    idle_seed = seed_of(mode_n);
    gen_next  = next_word(gen_mode, tx_word);
  end

  // Generator handshake: load seed on enable, advance on accept, drop valid
  // only after an accepted beat. A pending injection is folded into the next
  // word loaded, so TX_TDATA never changes while a beat is stalled.
  // NOTE: sequential state uses non-blocking assignments; when two assignments
  // to the same register fire in one cycle, the later one in the block wins.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      TX_TVALID <= 1'b0;
      TX_TDATA  <= idle_seed;
      tx_word   <= idle_seed;
      gen_mode  <= mode_n;
      inj_pend  <= 1'b0;
    end else begin
      if (INJ_ERR) inj_pend <= 1'b1;
      if (!TX_TVALID) begin
        gen_mode <= mode_n;
        tx_word  <= idle_seed;
        if (EN) begin
          TX_TVALID <= 1'b1;
          TX_TDATA  <= idle_seed ^ flip;
          inj_pend  <= 1'b0;
        end else begin
          TX_TDATA  <= idle_seed;
        end
      end else if (TX_TREADY) begin
        if (EN) begin
          tx_word  <= gen_next;
          TX_TDATA <= gen_next ^ flip;
          inj_pend <= 1'b0;
        end else begin
          TX_TVALID <= 1'b0;
          tx_word   <= idle_seed;
          TX_TDATA  <= idle_seed;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------
  chk_state_t            state;
  logic [1:0]            chk_mode;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [RUN_W-1:0]      run;
  logic [BAD_W-1:0]      bad;
  logic                  first_seen;

  logic                  match;
  logic                  mode_chg;
  logic [DATA_WIDTH-1:0] exp_next;
  logic [DATA_WIDTH-1:0] rx_reseed;
  logic [CNT_WIDTH-1:0]  word_base;
  logic [CNT_WIDTH-1:0]  err_base;
  logic                  first_base;

  // Compare and next-expected values; CLR makes a same-cycle locked beat
  // count on top of zeroed statistics.
  always_comb begin
    match      = (RX_TDATA == exp_word);
    mode_chg   = (mode_n != chk_mode);
    exp_next   = next_word(mode_n, exp_word);
    rx_reseed  = next_word(mode_n, RX_TDATA);
    word_base  = CLR ? '0 : WORD_CNT;
    err_base   = CLR ? '0 : ERR_CNT;
    first_base = CLR ? 1'b0 : first_seen;
  end

  // Checker FSM and statistics, all outputs registered.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state         <= ST_HUNT;
      chk_mode      <= mode_n;
      exp_word      <= '0;
      run           <= '0;
      bad           <= '0;
      first_seen    <= 1'b0;
      LOCKED        <= 1'b0;
      ERROR         <= 1'b0;
      ERR_CNT       <= '0;
      WORD_CNT      <= '0;
      FIRST_ERR_RX  <= '0;
      FIRST_ERR_EXP <= '0;
    end else begin
      chk_mode <= mode_n;

      if (CLR) begin
        WORD_CNT      <= '0;
        ERR_CNT       <= '0;
        ERROR         <= 1'b0;
        first_seen    <= 1'b0;
        FIRST_ERR_RX  <= '0;
        FIRST_ERR_EXP <= '0;
      end

      if (mode_chg) begin
        state  <= ST_HUNT;
        LOCKED <= 1'b0;
        run    <= '0;
        bad    <= '0;
      end else if (RX_TVALID) begin
        case (state)
          ST_HUNT: begin
            exp_word <= rx_reseed;
            run      <= '0;
            state    <= ST_SYNC;
          end

          ST_SYNC: begin
            if (match) begin
              exp_word <= exp_next;
              if (run == RUN_W'(LOCK_COUNT - 1)) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
                run    <= '0;
                bad    <= '0;
              end else begin
                run <= run + RUN_W'(1);
              end
            end else begin
              // Reseed from this beat, exactly as a fresh hunt would.
              exp_word <= rx_reseed;
              run      <= '0;
            end
          end

          ST_LOCKED: begin
            exp_word <= exp_next;
            WORD_CNT <= sat_inc(word_base);
            if (match) begin
              bad <= '0;
            end else begin
              ERR_CNT <= sat_inc(err_base);
              ERROR   <= 1'b1;
              if (!first_base) begin
                first_seen    <= 1'b1;
                FIRST_ERR_RX  <= RX_TDATA;
                FIRST_ERR_EXP <= exp_word;
              end
              if (bad == BAD_W'(LOSS_COUNT - 1)) begin
                state  <= ST_HUNT;
                LOCKED <= 1'b0;
                bad    <= '0;
              end else begin
                bad <= bad + BAD_W'(1);
              end
            end
          end

          default: begin
            state  <= ST_HUNT;
            LOCKED <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qeciphy_traffic_gen_chk.sv
// Bench for qeciphy_traffic_gen_chk: seed table, loopback soak in each
// pattern, error injection, loss of lock, CLR corner and counter saturation.
module tb_qeciphy_traffic_gen_chk;

  localparam int W   = 64;
  localparam int CW  = 32;
  localparam int WS  = 32;
  localparam int CWS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, looped back through an RX corruption mask.
  logic          arst = 1'b1, en = 1'b0, inj_err = 1'b0, clr = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          tx_tready = 1'b0, lb_en = 1'b0;
  logic [W-1:0]  rx_mask = '0;
  logic [W-1:0]  tx_tdata, rx_tdata, first_rx, first_exp;
  logic          tx_tvalid, rx_tvalid, rx_tready, locked, error;
  logic [CW-1:0] err_cnt, word_cnt;

  assign rx_tdata  = tx_tdata ^ rx_mask;
  assign rx_tvalid = lb_en & tx_tvalid & tx_tready;

  qeciphy_traffic_gen_chk #(
    .DATA_WIDTH(W), .CNT_WIDTH(CW), .LOCK_COUNT(4), .LOSS_COUNT(8)
  ) dut (
    .ACLK(clk), .ARST(arst), .EN(en), .MODE(mode), .INJ_ERR(inj_err), .CLR(clr),
    .TX_TDATA(tx_tdata), .TX_TVALID(tx_tvalid), .TX_TREADY(tx_tready),
    .RX_TDATA(rx_tdata), .RX_TVALID(rx_tvalid), .RX_TREADY(rx_tready),
    .LOCKED(locked), .ERROR(error), .ERR_CNT(err_cnt), .WORD_CNT(word_cnt),
    .FIRST_ERR_RX(first_rx), .FIRST_ERR_EXP(first_exp)
  );

  // Narrow-counter instance for saturation, looped back directly.
  logic           s_en = 1'b0, s_inj = 1'b0, s_clr = 1'b0, s_tready = 1'b1;
  logic [1:0]     s_mode = 2'd2;
  logic [WS-1:0]  s_tx_tdata, s_first_rx, s_first_exp;
  logic           s_tx_tvalid, s_rx_tready, s_locked, s_error;
  logic [CWS-1:0] s_err_cnt, s_word_cnt;

  qeciphy_traffic_gen_chk #(
    .DATA_WIDTH(WS), .CNT_WIDTH(CWS), .LOCK_COUNT(4), .LOSS_COUNT(8)
  ) dut_s (
    .ACLK(clk), .ARST(arst), .EN(s_en), .MODE(s_mode), .INJ_ERR(s_inj), .CLR(s_clr),
    .TX_TDATA(s_tx_tdata), .TX_TVALID(s_tx_tvalid), .TX_TREADY(s_tready),
    .RX_TDATA(s_tx_tdata), .RX_TVALID(s_tx_tvalid & s_tready), .RX_TREADY(s_rx_tready),
    .LOCKED(s_locked), .ERROR(s_error), .ERR_CNT(s_err_cnt), .WORD_CNT(s_word_cnt),
    .FIRST_ERR_RX(s_first_rx), .FIRST_ERR_EXP(s_first_exp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard of expected TX words, consumed on each accepted beat.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] prev_data;
  logic         prev_stall = 1'b0;
  logic         sb_on      = 1'b0;
  logic         allow_bit0 = 1'b0;
  int           bit0_flips = 0;

  task automatic push_incr(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(W'(k));
  endtask

  // Bit-serial PRBS-31 reference: emit the oldest history bit, append the new one.
  task automatic push_prbs(input int n);
    logic [30:0]  hist;
    logic [W-1:0] word;
    hist = '1;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < W; i++) begin
        word[i] = hist[0];
        hist    = {hist[0] ^ hist[3], hist[30:1]};
      end
      exp_q.push_back(word);
    end
  endtask

  // TX monitor: compares accepted words and holds stability while stalled.
  always @(negedge clk) begin
    if (sb_on) begin
      if (prev_stall) begin
        check("tx_hold_data", tx_tdata, prev_data);
        check("tx_hold_valid", 64'(tx_tvalid), 64'd1);
      end
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          check("tx_sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          if (allow_bit0 && ((tx_tdata ^ mon_exp) == W'(1))) bit0_flips++;
          else check("tx_word", tx_tdata, mon_exp);
        end
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev_data  = tx_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] seed;
    logic [W-1:0] word1;
  } seed_vec_t;

  seed_vec_t vecs[4];
  int        beat;
  int        guard;

  initial begin
    vecs[0] = '{mode: 2'd0, seed: 64'h0,                     word1: 64'h1};
    vecs[1] = '{mode: 2'd1, seed: 64'h38000000_7FFFFFFF,     word1: 64'h0E380000_1F800000};
    vecs[2] = '{mode: 2'd2, seed: 64'h1,                     word1: 64'h2};
    vecs[3] = '{mode: 2'd3, seed: 64'h0,                     word1: 64'h1};

    // Reset state.
    step();
    step();
    check("rst_rx_tready", 64'(rx_tready), 64'd1);
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tdata", tx_tdata, 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_first_rx", first_rx, 64'd0);
    check("rst_first_exp", first_exp, 64'd0);

    // Seed table: reset value, first beat, second beat, valid drop on EN=0.
    for (int i = 0; i < 4; i++) begin
      arst = 1'b1; mode = vecs[i].mode; en = 1'b0; tx_tready = 1'b1; lb_en = 1'b0;
      step();
      check($sformatf("seed_rst_m%0d", i), tx_tdata, vecs[i].seed);
      arst = 1'b0; en = 1'b1;
      step();
      check($sformatf("seed_valid_m%0d", i), 64'(tx_tvalid), 64'd1);
      check($sformatf("seed_word0_m%0d", i), tx_tdata, vecs[i].seed);
      step();
      check($sformatf("seed_word1_m%0d", i), tx_tdata, vecs[i].word1);
      en = 1'b0;
      step();
      check($sformatf("seed_drop_m%0d", i), 64'(tx_tvalid), 64'd0);
    end

    // Increment loopback: lock timing and 1000-beat statistics.
    arst = 1'b1; mode = 2'd0; en = 1'b0; tx_tready = 1'b1;
    step();
    arst = 1'b0;
    exp_q.delete();
    push_incr(1100);
    sb_on = 1'b1; lb_en = 1'b1; en = 1'b1;
    beat = 0; guard = 0;
    while (beat < 1000 && guard < 3000) begin
      step();
      guard++;
      if (rx_tvalid) begin
        if (beat == 4) check("inc_lock_low_beat4", 64'(locked), 64'd0);
        if (beat == 5) check("inc_lock_high_beat5", 64'(locked), 64'd1);
        beat++;
      end
    end
    check("inc_beats_seen", 64'(beat), 64'd1000);
    step();
    tx_tready = 1'b0; lb_en = 1'b0;
    check("inc_word_cnt", 64'(word_cnt), 64'd995);
    check("inc_err_cnt", 64'(err_cnt), 64'd0);
    check("inc_locked", 64'(locked), 64'd1);
    check("inc_error", 64'(error), 64'd0);

    // PRBS-31 loopback with random TX_TREADY stalls.
    sb_on = 1'b0;
    arst = 1'b1; mode = 2'd1; en = 1'b0;
    step();
    arst = 1'b0;
    exp_q.delete();
    push_prbs(600);
    sb_on = 1'b1; lb_en = 1'b1; en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tx_tready = 1'($urandom_range(0, 1));
      step();
    end
    tx_tready = 1'b1;
    repeat (20) step();
    check("prbs_locked", 64'(locked), 64'd1);
    check("prbs_err_cnt", 64'(err_cnt), 64'd0);
    check("prbs_error", 64'(error), 64'd0);

    // Single injected error while locked.
    allow_bit0 = 1'b1; bit0_flips = 0;
    inj_err = 1'b1;
    step();
    inj_err = 1'b0;
    repeat (20) step();
    check("inj_bit0_flips", 64'(bit0_flips), 64'd1);
    check("inj_err_cnt", 64'(err_cnt), 64'd1);
    check("inj_error", 64'(error), 64'd1);
    check("inj_first_diff", first_rx ^ first_exp, 64'd1);
    check("inj_locked", 64'(locked), 64'd1);
    allow_bit0 = 1'b0;

    // CLR coinciding with a clean locked beat, then 8 corrupted RX beats.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_clean_word_cnt", 64'(word_cnt), 64'd1);
    check("clr_clean_err_cnt", 64'(err_cnt), 64'd0);
    check("clr_clean_error", 64'(error), 64'd0);
    rx_mask = '1;
    repeat (7) step();
    check("loss_locked_after7", 64'(locked), 64'd1);
    step();
    rx_mask = '0;
    check("loss_locked_after8", 64'(locked), 64'd0);
    check("loss_err_cnt", 64'(err_cnt), 64'd8);
    check("loss_error", 64'(error), 64'd1);
    repeat (4) step();
    check("relock_after4", 64'(locked), 64'd0);
    step();
    check("relock_after5", 64'(locked), 64'd1);
    check("relock_err_kept", 64'(err_cnt), 64'd8);

    // CLR coinciding with a mismatching locked beat.
    clr = 1'b1; rx_mask = W'(1);
    step();
    clr = 1'b0; rx_mask = '0;
    check("clr_bad_err_cnt", 64'(err_cnt), 64'd1);
    check("clr_bad_word_cnt", 64'(word_cnt), 64'd1);
    check("clr_bad_error", 64'(error), 64'd1);
    check("clr_bad_first_diff", first_rx ^ first_exp, 64'd1);
    check("clr_bad_locked", 64'(locked), 64'd1);
    sb_on = 1'b0;

    // EN low while stalled: valid holds until accepted, then restart from seed.
    tx_tready = 1'b0;
    step();
    en = 1'b0;
    step();
    step();
    check("en_low_stall_hold", 64'(tx_tvalid), 64'd1);
    tx_tready = 1'b1;
    step();
    check("en_low_drop", 64'(tx_tvalid), 64'd0);
    en = 1'b1; tx_tready = 1'b0;
    step();
    check("restart_valid", 64'(tx_tvalid), 64'd1);
    check("restart_seed", tx_tdata, 64'h38000000_7FFFFFFF);

    // Reset while a beat is stalled.
    check("pre_rst_locked", 64'(locked), 64'd1);
    arst = 1'b1;
    step();
    check("midrst_tvalid", 64'(tx_tvalid), 64'd0);
    check("midrst_locked", 64'(locked), 64'd0);
    check("midrst_word_cnt", 64'(word_cnt), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_error", 64'(error), 64'd0);
    check("midrst_rx_tready", 64'(rx_tready), 64'd1);
    en = 1'b0; lb_en = 1'b0;
    arst = 1'b0;

    // Saturation on the narrow-counter instance (walking-one, 32 bit).
    arst = 1'b1; s_mode = 2'd2;
    step();
    arst = 1'b0; s_en = 1'b1;
    repeat (20) step();
    check("sat_locked", 64'(s_locked), 64'd1);
    check("sat_word_cnt", 64'(s_word_cnt), 64'd7);
    check("sat_err_cnt0", 64'(s_err_cnt), 64'd0);
    for (int i = 0; i < 10; i++) begin
      s_inj = 1'b1;
      step();
      s_inj = 1'b0;
      step();
    end
    repeat (4) step();
    check("sat_err_cnt", 64'(s_err_cnt), 64'd7);
    check("sat_error", 64'(s_error), 64'd1);
    check("sat_locked_kept", 64'(s_locked), 64'd1);
    check("sat_word_cnt_kept", 64'(s_word_cnt), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
